counter_cmd_seq: RTL and testbench

Command sequencer sitting directly upstream of the 16-bit up/down `Counter`. Accepts LOAD / UP / DOWN / HOLD commands over a valid/ready handshake and expands each into the cycle-accurate `data_in`, `ld_cnt`, `updn_cnt` and `count_enb` pattern the counter consumes. Keeps a shadow copy of the expected counter value for bring-up and checking.

---
 rtl/counter_cmd_seq.sv | 142 ++++++++++++++
 tb/tb_counter_cmd_seq.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/counter_cmd_seq.sv
// Command sequencer for the 16-bit up/down counter: expands LOAD/UP/DOWN/HOLD
// commands into registered counter controls and tracks a shadow of the count.
module counter_cmd_seq #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_,
  input  logic             i_cmd_valid,
  output logic             o_cmd_ready,
  input  logic [1:0]       i_cmd_op,
  input  logic [WIDTH-1:0] i_cmd_arg,
  input  logic             i_abort,
  output logic [WIDTH-1:0] o_data_in,
  output logic             o_ld_cnt,
  output logic             o_updn_cnt,
  output logic             o_count_enb,
  output logic             o_done,
  output logic [WIDTH-1:0] o_shadow_cnt,
  output logic [1:0]       o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_WAIT = 2'd3
  } state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;

  localparam logic [WIDTH-1:0] W_ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  // Handshake: a command transfers on a posedge where i_cmd_valid and
  // o_cmd_ready are both high; o_cmd_ready depends only on state (IDLE).
  state_t           r_state,     w_state_nxt;
  logic [WIDTH-1:0] r_remain,    w_remain_nxt;
  logic [WIDTH-1:0] r_data_in,   w_data_in_nxt;
  logic [WIDTH-1:0] r_shadow;
  logic             r_ld_cnt,    w_ld_cnt_nxt;
  logic             r_updn_cnt,  w_updn_cnt_nxt;
  logic             r_count_enb, w_count_enb_nxt;
  logic             r_done,      w_done_nxt;
  logic             r_zero_pend, w_zero_pend_nxt;
  logic             w_accept;

  assign w_accept = i_cmd_valid && (r_state == S_IDLE);

  always_ff @(posedge i_clk) begin
    if (!i_rst_) begin
      r_state     <= S_IDLE;
      r_remain    <= '0;
      r_data_in   <= '0;
      r_ld_cnt    <= 1'b1;
      r_updn_cnt  <= 1'b1;
      r_count_enb <= 1'b0;
      r_done      <= 1'b0;
      r_zero_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_remain    <= w_remain_nxt;
      r_data_in   <= w_data_in_nxt;
      r_ld_cnt    <= w_ld_cnt_nxt;
      r_updn_cnt  <= w_updn_cnt_nxt;
      r_count_enb <= w_count_enb_nxt;
      r_done      <= w_done_nxt;
      r_zero_pend <= w_zero_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_remain_nxt    = r_remain;
    w_data_in_nxt   = r_data_in;
    w_ld_cnt_nxt    = 1'b1;
    w_updn_cnt_nxt  = r_updn_cnt;
    w_count_enb_nxt = 1'b0;
    // A zero-length command completes one cycle after it was accepted.
    w_done_nxt      = r_zero_pend;
    w_zero_pend_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (i_cmd_op == OP_LOAD) begin
            w_state_nxt   = S_LOAD;
            w_ld_cnt_nxt  = 1'b0;
            w_data_in_nxt = i_cmd_arg;
          end else if (i_cmd_arg == '0) begin
            w_zero_pend_nxt = 1'b1;
          end else if (i_cmd_op == OP_UP || i_cmd_op == OP_DOWN) begin
            w_state_nxt     = S_RUN;
            w_remain_nxt    = i_cmd_arg;
            w_count_enb_nxt = 1'b1;
            w_updn_cnt_nxt  = (i_cmd_op == OP_UP);
          end else begin
            w_state_nxt  = S_WAIT;
            w_remain_nxt = i_cmd_arg;
          end
        end
      end
      S_LOAD: begin
        w_state_nxt = S_IDLE;
        w_done_nxt  = 1'b1;
      end
      S_RUN, S_WAIT: begin
        // Abort beats completion; the count on this edge still happens.
        w_remain_nxt = r_remain - W_ONE;
        if (i_abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_remain == W_ONE) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end else begin
          w_count_enb_nxt = (r_state == S_RUN);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Shadow follows the same load-over-count priority as the real counter.
  always_ff @(posedge i_clk) begin
    if (!i_rst_) begin
      r_shadow <= '0;
    end else if (!r_ld_cnt) begin
      r_shadow <= r_data_in;
    end else if (r_count_enb) begin
      r_shadow <= r_updn_cnt ? (r_shadow + W_ONE) : (r_shadow - W_ONE);
    end
  end

  assign o_cmd_ready  = (r_state == S_IDLE);
  assign o_data_in    = r_data_in;
  assign o_ld_cnt     = r_ld_cnt;
  assign o_updn_cnt   = r_updn_cnt;
  assign o_count_enb  = r_count_enb;
  assign o_done       = r_done;
  assign o_shadow_cnt = r_shadow;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_counter_cmd_seq.sv
// Bench for counter_cmd_seq: directed scenarios plus random command streams,
// checked against a command-level model of the counter and handshake timing.
module tb_counter_cmd_seq;

  localparam int W = 16;
  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_HOLD = 2'b11;

  logic         i_clk = 1'b0;
  logic         i_rst_ = 1'b0;
  logic         i_cmd_valid = 1'b0;
  logic [1:0]   i_cmd_op = 2'b00;
  logic [W-1:0] i_cmd_arg = '0;
  logic         i_abort = 1'b0;
  logic         o_cmd_ready, o_ld_cnt, o_updn_cnt, o_count_enb, o_done;
  logic [W-1:0] o_data_in, o_shadow_cnt;
  logic [1:0]   o_dbg_state;

  int n_vec = 0;
  int n_err = 0;

  logic [W-1:0] m_cnt  = '0;
  logic         m_dir  = 1'b1;
  logic [W-1:0] m_data = '0;
  logic [W-1:0] exp_q[$];

  counter_cmd_seq #(.WIDTH(W)) dut (
    .i_clk(i_clk), .i_rst_(i_rst_), .i_cmd_valid(i_cmd_valid),
    .o_cmd_ready(o_cmd_ready), .i_cmd_op(i_cmd_op), .i_cmd_arg(i_cmd_arg),
    .i_abort(i_abort), .o_data_in(o_data_in), .o_ld_cnt(o_ld_cnt),
    .o_updn_cnt(o_updn_cnt), .o_count_enb(o_count_enb), .o_done(o_done),
    .o_shadow_cnt(o_shadow_cnt), .o_dbg_state(o_dbg_state)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic check_outs(input logic ld, input logic ce, input logic [W-1:0] sh,
                            input logic dn, input logic rdy);
    check("ld_cnt",     32'(o_ld_cnt),     32'(ld));
    check("count_enb",  32'(o_count_enb),  32'(ce));
    check("updn_cnt",   32'(o_updn_cnt),   32'(m_dir));
    check("data_in",    32'(o_data_in),    32'(m_data));
    check("done",       32'(o_done),       32'(dn));
    check("cmd_ready",  32'(o_cmd_ready),  32'(rdy));
    check("shadow_cnt", 32'(o_shadow_cnt), 32'(sh));
  endtask

  // Issues one command from IDLE and follows it to completion or abort.
  // abort_at = k raises abort during the k-th busy cycle (0 = never).
  task automatic do_cmd(input logic [1:0] op, input logic [W-1:0] arg,
                        input int abort_at, input bit junk);
    bit run;
    bit aborted;
    logic [W-1:0] v;
    logic [W-1:0] exp_sh;
    check("ready_at_issue", 32'(o_cmd_ready), 32'd1);
    i_cmd_valid = 1'b1;
    i_cmd_op    = op;
    i_cmd_arg   = arg;
    i_abort     = 1'($urandom_range(0, 1));
    tick();
    i_cmd_valid = 1'b0;
    i_abort     = 1'b0;
    if (op == OP_LOAD) begin
      m_data = arg;
      check_outs(1'b0, 1'b0, m_cnt, 1'b0, 1'b0);
      i_abort = 1'($urandom_range(0, 1));
      tick();
      i_abort = 1'b0;
      m_cnt = arg;
      check_outs(1'b1, 1'b0, m_cnt, 1'b1, 1'b1);
    end else if (arg == '0) begin
      check_outs(1'b1, 1'b0, m_cnt, 1'b0, 1'b1);
      tick();
      check_outs(1'b1, 1'b0, m_cnt, 1'b1, 1'b1);
    end else begin
      run = (op != OP_HOLD);
      if (run) m_dir = (op == OP_UP);
      exp_q.delete();
      v = m_cnt;
      for (int j = 0; j <= int'(arg); j++) begin
        exp_q.push_back(v);
        if (run) v = m_dir ? v + 1'b1 : v - 1'b1;
      end
      aborted = 1'b0;
      for (int j = 1; j <= int'(arg); j++) begin
        exp_sh = exp_q.pop_front();
        check_outs(1'b1, run, exp_sh, 1'b0, 1'b0);
        if (j == abort_at) begin
          i_abort = 1'b1;
        end else if (junk && j < int'(arg)) begin
          i_cmd_valid = 1'($urandom_range(0, 1));
          i_cmd_op    = 2'($urandom_range(0, 3));
          i_cmd_arg   = W'($urandom);
        end
        tick();
        i_abort     = 1'b0;
        i_cmd_valid = 1'b0;
        if (j == abort_at) begin
          aborted = 1'b1;
          break;
        end
      end
      m_cnt = exp_q.pop_front();
      exp_q.delete();
      check_outs(1'b1, 1'b0, m_cnt, !aborted, 1'b1);
    end
  endtask

  task automatic idle_cycle();
    tick();
    check_outs(1'b1, 1'b0, m_cnt, 1'b0, 1'b1);
  endtask

  initial begin
    logic [1:0]   op;
    logic [W-1:0] arg;
    int           ab;

    i_rst_ = 1'b0;
    tick();
    tick();
    i_rst_ = 1'b1;
    check_outs(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
    idle_cycle();

    do_cmd(OP_LOAD, 16'd10, 0, 1'b0);
    do_cmd(OP_UP, 16'd3, 0, 1'b0);
    check("up3_result", 32'(o_shadow_cnt), 32'd13);
    idle_cycle();

    do_cmd(OP_LOAD, 16'h0001, 0, 1'b0);
    do_cmd(OP_DOWN, 16'd3, 0, 1'b0);
    check("wrap_result", 32'(o_shadow_cnt), 32'hFFFE);
    idle_cycle();
    check("dir_retained", 32'(o_updn_cnt), 32'd0);

    do_cmd(OP_HOLD, 16'd4, 0, 1'b1);
    do_cmd(OP_UP, 16'd0, 0, 1'b0);
    do_cmd(OP_LOAD, 16'd7, 0, 1'b0);
    do_cmd(OP_UP, 16'd5, 2, 1'b0);
    check("abort_mid", 32'(o_shadow_cnt), 32'd9);
    do_cmd(OP_LOAD, 16'd7, 0, 1'b0);
    do_cmd(OP_UP, 16'd5, 5, 1'b0);
    check("abort_last", 32'(o_shadow_cnt), 32'd12);
    do_cmd(OP_HOLD, 16'd3, 3, 1'b0);

    // Reset in the middle of UP 10 from 3.
    do_cmd(OP_LOAD, 16'd3, 0, 1'b0);
    i_cmd_valid = 1'b1;
    i_cmd_op    = OP_UP;
    i_cmd_arg   = 16'd10;
    tick();
    i_cmd_valid = 1'b0;
    tick();
    tick();
    check("pre_reset_cnt", 32'(o_shadow_cnt), 32'd5);
    i_rst_ = 1'b0;
    tick();
    i_rst_ = 1'b1;
    m_cnt  = '0;
    m_dir  = 1'b1;
    m_data = '0;
    check_outs(1'b1, 1'b0, 16'h0000, 1'b0, 1'b1);
    do_cmd(OP_LOAD, 16'd5, 0, 1'b0);

    for (int i = 0; i < 80; i++) begin
      op  = 2'($urandom_range(0, 3));
      arg = (op == OP_LOAD) ? W'($urandom) : W'($urandom_range(0, 9));
      ab  = ($urandom_range(0, 3) == 0 && arg != '0) ? int'($urandom_range(1, int'(arg))) : 0;
      do_cmd(op, arg, ab, 1'b1);
      for (int g = int'($urandom_range(0, 2)); g > 0; g--) idle_cycle();
    end

    do_cmd(OP_LOAD, 16'h1234, 0, 1'b0);
    do_cmd(OP_UP, 16'hFFFF, 0, 1'b0);
    check("max_n_result", 32'(o_shadow_cnt), 32'h1233);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
